// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and frame constants
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} uart_state_t;
    localparam int UART_DATA_BITS = 8;
    localparam logic UART_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line plus held data/valid consumer interface
interface uart_receiver_if;
    import uart_pkg::*;
    logic rx;
    logic read_en;
    logic [UART_DATA_BITS-1:0] data;
    logic valid;
    logic busy;
    logic frame_err;
    logic overrun;
    modport master (input rx, read_en, output data, valid, busy, frame_err, overrun);
    modport slave (output rx, read_en, input data, valid, busy, frame_err, overrun);
endinterface

// File: rtl/uart_sync.sv
// uart_sync: multi-flop synchronizer, resets to the line idle level
module uart_sync
    import uart_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;
    always_ff @(posedge clk or posedge rst)
        if (rst) chain <= {STAGES{UART_IDLE_LEVEL}};
        else chain <= {chain[STAGES-2:0], d};
    assign q = chain[STAGES-1];
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial-to-parallel receiver with held data/valid,
// frame error pulse and sticky overrun
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    uart_receiver_if.master bus
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [2:0] IDX_LAST = 3'(UART_DATA_BITS - 1);
    uart_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0] idx, idx_n;
    logic rx_s, shift_en, done, ferr;
    logic [UART_DATA_BITS-1:0] shreg, data;
    logic valid, overrun, frame_err;
    uart_sync #(.STAGES(SYNC_STAGES)) sync_i (.clk(clk), .rst(rst), .d(bus.rx), .q(rx_s));
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            idx <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            idx <= idx_n;
        end
    always_comb begin
        state_n = state;
        cnt_n = cnt + CW'(1);
        idx_n = idx;
        shift_en = 1'b0;
        done = 1'b0;
        ferr = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                state_n = rx_s ? IDLE : START;
            end
            START: if (cnt == HALF) begin
                cnt_n = '0;
                idx_n = '0;
                state_n = rx_s ? IDLE : DATA;
            end
            DATA: if (cnt == LAST) begin
                cnt_n = '0;
                shift_en = 1'b1;
                idx_n = (idx == IDX_LAST) ? '0 : idx + 3'd1;
                state_n = (idx == IDX_LAST) ? STOP : DATA;
            end
            // Sampling mid-stop returns to IDLE half a bit early for back-to-back frames
            STOP: if (cnt == LAST) begin
                cnt_n = '0;
                done = rx_s;
                ferr = ~rx_s;
                state_n = rx_s ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                cnt_n = '0;
                state_n = rx_s ? IDLE : WAIT_HIGH;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            shreg <= '0;
            data <= '0;
            valid <= 1'b0;
            overrun <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (shift_en) shreg[idx] <= rx_s;
            if (done) data <= shreg;
            valid <= done | (valid & ~bus.read_en);
            overrun <= ((done & valid) | overrun) & ~bus.read_en;
            frame_err <= ferr;
        end
    assign bus.data = data;
    assign bus.valid = valid;
    assign bus.busy = (state != IDLE);
    assign bus.frame_err = frame_err;
    assign bus.overrun = overrun;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and randomized frames checked against a byte-level model
module tb_uart_receiver;
    localparam int CPB = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int ferr_pulses = 0;
    logic [7:0] exp_data;
    logic exp_valid, exp_ov;
    uart_receiver_if bus ();
    uart_receiver #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    always @(negedge clk) if (bus.frame_err === 1'b1) ferr_pulses++;
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic send_bit(input logic b);
        bus.rx = b;
        ticks(CPB);
    endtask
    task automatic send_byte(input logic [7:0] b, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask
    task automatic read_pulse();
        bus.read_en = 1'b1;
        ticks(1);
        bus.read_en = 1'b0;
    endtask
    task automatic wait_valid(input int lim);
        int n = 0;
        while (bus.valid !== 1'b1 && n < lim) begin
            ticks(1);
            n++;
        end
        check("valid_timeout", bus.valid, 1'b1);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        logic [7:0] q[2];
        int p0;
        bus.rx = 1'b1;
        bus.read_en = 1'b0;
        ticks(3);
        check("rst_data", bus.data, 8'h00);
        check("rst_overrun", bus.overrun, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            check("idle_valid", bus.valid, 1'b0);
            check("idle_busy", bus.busy, 1'b0);
            check("idle_ferr", bus.frame_err, 1'b0);
            ticks(1);
        end
        send_byte(8'h55, 1'b1);
        ticks(2);
        check("single_data", bus.data, 8'h55);
        check("single_valid", bus.valid, 1'b1);
        check("single_busy", bus.busy, 1'b0);
        check("single_ov", bus.overrun, 1'b0);
        read_pulse();
        check("single_read", bus.valid, 1'b0);
        q[0] = 8'hA3;
        q[1] = 8'h0F;
        fork
            begin
                send_byte(q[0], 1'b1);
                send_byte(q[1], 1'b1);
            end
            for (int k = 0; k < 2; k++) begin
                wait_valid(100);
                check("b2b_data", bus.data, q[k]);
                check("b2b_ov", bus.overrun, 1'b0);
                read_pulse();
            end
        join
        check("b2b_valid", bus.valid, 1'b0);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        ticks(2);
        check("ovr_data", bus.data, 8'h22);
        check("ovr_valid", bus.valid, 1'b1);
        check("ovr_flag", bus.overrun, 1'b1);
        read_pulse();
        check("ovr_clear", bus.overrun, 1'b0);
        check("ovr_valid_clear", bus.valid, 1'b0);
        p0 = ferr_pulses;
        send_byte(8'hFF, 1'b0);
        bus.rx = 1'b0;
        ticks(20);
        check("break_busy", bus.busy, 1'b1);
        check("break_valid", bus.valid, 1'b0);
        bus.rx = 1'b1;
        ticks(6);
        check("ferr_pulses", 8'(ferr_pulses - p0), 8'd1);
        check("ferr_busy", bus.busy, 1'b0);
        check("ferr_valid", bus.valid, 1'b0);
        send_byte(8'h3C, 1'b1);
        ticks(2);
        check("after_ferr_data", bus.data, 8'h3C);
        check("after_ferr_valid", bus.valid, 1'b1);
        p0 = ferr_pulses;
        bus.rx = 1'b0;
        ticks(1);
        bus.rx = 1'b1;
        ticks(2);
        check("glitch_seen", bus.busy, 1'b1);
        ticks(10);
        check("glitch_busy", bus.busy, 1'b0);
        check("glitch_data", bus.data, 8'h3C);
        check("glitch_valid", bus.valid, 1'b1);
        check("glitch_ferr", 8'(ferr_pulses - p0), 8'd0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rst = 1'b1;
        bus.rx = 1'b1;
        ticks(1);
        check("midrst_data", bus.data, 8'h00);
        check("midrst_valid", bus.valid, 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_ov", bus.overrun, 1'b0);
        check("midrst_ferr", bus.frame_err, 1'b0);
        ticks(2);
        rst = 1'b0;
        ticks(5);
        send_byte(8'hC5, 1'b1);
        ticks(2);
        check("postrst_data", bus.data, 8'hC5);
        check("postrst_valid", bus.valid, 1'b1);
        read_pulse();
        exp_valid = 1'b0;
        exp_ov = 1'b0;
        for (int n = 0; n < 40; n++) begin
            logic [7:0] b;
            int mode;
            b = 8'($urandom);
            mode = $urandom_range(0, 2);
            ticks($urandom_range(0, 6));
            send_byte(b, 1'b1);
            if (mode == 2) bus.read_en = 1'b1;
            ticks(1);
            bus.read_en = 1'b0;
            ticks(1);
            exp_ov = (mode == 2) ? 1'b0 : (exp_ov | exp_valid);
            exp_valid = 1'b1;
            exp_data = b;
            check("rnd_data", bus.data, exp_data);
            check("rnd_valid", bus.valid, exp_valid);
            check("rnd_ov", bus.overrun, exp_ov);
            if (mode == 1) begin
                read_pulse();
                exp_valid = 1'b0;
                exp_ov = 1'b0;
                check("rnd_read_valid", bus.valid, exp_valid);
                check("rnd_read_ov", bus.overrun, exp_ov);
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
